// File: rtl/my_fifo_pkg.sv
// -----------------------------------------------------------------------------
// my_fifo_pkg
// Shared definitions for the FIFO family: size limits, a constant-foldable
// clog2, the level-counter width derivation and the FWFT output-stage source
// encoding.
// -----------------------------------------------------------------------------
package my_fifo_pkg;

  localparam int MAX_DEPTH = 4096;
  localparam int MAX_WIDTH = 72;

  // Which register currently drives dout in first-word-fall-through builds.
  typedef enum logic {
    SRC_BYPASS = 1'b0,
    SRC_RAM    = 1'b1
  } outSrc_e;

  // Number of address bits needed to index 'value' entries.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // The level counter must represent 0..depth inclusive, so it needs one bit
  // more than the address.
  function automatic int levelWidth(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/my_fifo_ram.sv
// -----------------------------------------------------------------------------
// my_fifo_ram
// Simple dual-port storage, WIDTH x DEPTH, synchronous write and registered
// read, written so synthesis maps it onto block RAM. Only the read output
// register is reset; the array itself is not.
//
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset of the read register
//   wrEn_i     write strobe
//   wrAddr_i   write address
//   wrData_i   write data
//   rdEn_i     read strobe; rdData_o updates on the following edge
//   rdAddr_i   read address
//   rdData_o   registered read data, holds when rdEn_i is low
// -----------------------------------------------------------------------------
module my_fifo_ram
  import my_fifo_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2048
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wrEn_i,
  input  logic [clog2(DEPTH)-1:0] wrAddr_i,
  input  logic [WIDTH-1:0]        wrData_i,
  input  logic                    rdEn_i,
  input  logic [clog2(DEPTH)-1:0] rdAddr_i,
  output logic [WIDTH-1:0]        rdData_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdData_q;

  always_ff @(posedge clk) begin
    if (wrEn_i) mem[wrAddr_i] <= wrData_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdData_q <= '0;
    end else if (rdEn_i) begin
      rdData_q <= mem[rdAddr_i];
    end
  end

  assign rdData_o = rdData_q;

endmodule

// File: rtl/my_sync_fifo.sv
// -----------------------------------------------------------------------------
// my_sync_fifo
// Single-clock FIFO with level counter, registered full/empty/almost flags and
// one-cycle error pulses for rejected writes and reads. Storage lives in
// my_fifo_ram; all control stays here.
//
// Build option
//   MY_SYNC_FIFO_FWFT_EN  defined: first-word-fall-through, dout shows the head
//                         entry whenever empty is low. Undefined: standard
//                         mode, dout shows the popped word one cycle after an
//                         accepted read and holds otherwise.
//
// Ports
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset (highest priority)
//   clr          synchronous flush, overrides wr_en/rd_en
//   din          write data
//   wr_en        write request
//   rd_en        read request
//   dout         read data
//   full         level == DEPTH
//   empty        level == 0
//   almostfull   level >= DEPTH-AFULL_OFFSET
//   almostempty  level <= AEMPTY_OFFSET
//   level        current occupancy
//   wrerr        pulse: a write was rejected because the FIFO was full
//   rderr        pulse: a read was rejected because the FIFO was empty
// -----------------------------------------------------------------------------
module my_sync_fifo
  import my_fifo_pkg::*;
#(
  parameter int WIDTH         = 9,
  parameter int DEPTH         = 2048,
  parameter int AFULL_OFFSET  = 128,
  parameter int AEMPTY_OFFSET = 128
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic [WIDTH-1:0]              din,
  input  logic                          wr_en,
  input  logic                          rd_en,
  output logic [WIDTH-1:0]              dout,
  output logic                          full,
  output logic                          empty,
  output logic                          almostfull,
  output logic                          almostempty,
  output logic [levelWidth(DEPTH)-1:0]  level,
  output logic                          wrerr,
  output logic                          rderr
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = levelWidth(DEPTH);

  localparam logic [LW-1:0] DEPTH_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_LVL  = LW'(DEPTH - AFULL_OFFSET);
  localparam logic [LW-1:0] AEMPTY_LVL = LW'(AEMPTY_OFFSET);

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             full_q, empty_q, afull_q, aempty_q;
  logic             wrerr_q, rderr_q;

  logic             wrAccept, rdAccept;
  logic             ramWe, ramRe;
  logic [WIDTH-1:0] ramQ;

  // A flush cancels any operation presented in the same cycle.
  assign wrAccept = wr_en & ~full_q  & ~clr;
  assign rdAccept = rd_en & ~empty_q & ~clr;

`ifdef MY_SYNC_FIFO_FWFT_EN
  // The output stage holds the head word; RAM holds everything behind it.
  // A write that would otherwise land in an empty output stage is bypassed
  // straight into it so dout is valid one cycle after the write edge.
  outSrc_e          src_q;
  logic [WIDTH-1:0] bypass_q;
  logic             memEmpty;
  logic             toBypass;

  assign memEmpty = empty_q | (level_q == LW'(1));
  assign toBypass = wrAccept & (empty_q | (rdAccept & memEmpty));
  assign ramWe    = wrAccept & ~toBypass;
  assign ramRe    = rdAccept & ~memEmpty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bypass_q <= '0;
      src_q    <= SRC_BYPASS;
    end else if (!clr) begin
      if (toBypass) begin
        bypass_q <= din;
        src_q    <= SRC_BYPASS;
      end else if (ramRe) begin
        src_q    <= SRC_RAM;
      end
    end
  end

  assign dout = (src_q == SRC_RAM) ? ramQ : bypass_q;
`else
  assign ramWe = wrAccept;
  assign ramRe = rdAccept;
  assign dout  = ramQ;
`endif

  always_comb begin
    level_d = level_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (clr) begin
      level_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      case ({wrAccept, rdAccept})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      if (ramWe) wptr_d = wptr_q + AW'(1);
      if (ramRe) rptr_d = rptr_q + AW'(1);
    end
  end

  // Flags are computed from the next level so they switch on the same edge
  // as level itself.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      wrerr_q  <= 1'b0;
      rderr_q  <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      full_q   <= (level_d == DEPTH_LVL);
      empty_q  <= (level_d == '0);
      afull_q  <= (level_d >= AFULL_LVL);
      aempty_q <= (level_d <= AEMPTY_LVL);
      wrerr_q  <= wr_en & full_q  & ~clr;
      rderr_q  <= rd_en & empty_q & ~clr;
    end
  end

  my_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) uRam (
    .clk      (clk),
    .rst_n    (rst_n),
    .wrEn_i   (ramWe),
    .wrAddr_i (wptr_q),
    .wrData_i (din),
    .rdEn_i   (ramRe),
    .rdAddr_i (rptr_q),
    .rdData_o (ramQ)
  );

  assign full        = full_q;
  assign empty       = empty_q;
  assign almostfull  = afull_q;
  assign almostempty = aempty_q;
  assign level       = level_q;
  assign wrerr       = wrerr_q;
  assign rderr       = rderr_q;

endmodule

// File: tb/tb_my_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_my_sync_fifo
// Self-checking bench for my_sync_fifo with WIDTH=9, DEPTH=16, AFULL_OFFSET=4,
// AEMPTY_OFFSET=2. A queue holds the words the FIFO should contain; accepted
// writes push to it and accepted reads pop the expected output word.
// -----------------------------------------------------------------------------
module tb_my_sync_fifo;

  localparam int WIDTH  = 9;
  localparam int DEPTH  = 16;
  localparam int AFOFF  = 4;
  localparam int AEOFF  = 2;
  localparam int LW     = 5;

  logic             clk;
  logic             rst_n;
  logic             clr;
  logic [WIDTH-1:0] din;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             full, empty, almostfull, almostempty;
  logic [LW-1:0]    level;
  logic             wrerr, rderr;

  int assertCount = 0;
  int failCount   = 0;

  logic [WIDTH-1:0] scoreboard[$];
  logic [WIDTH-1:0] expDout;
  logic             expWrerr, expRderr;

  my_sync_fifo #(
    .WIDTH         (WIDTH),
    .DEPTH         (DEPTH),
    .AFULL_OFFSET  (AFOFF),
    .AEMPTY_OFFSET (AEOFF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .din         (din),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .dout        (dout),
    .full        (full),
    .empty       (empty),
    .almostfull  (almostfull),
    .almostempty (almostempty),
    .level       (level),
    .wrerr       (wrerr),
    .rderr       (rderr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of stimulus, advances the model across the same edge,
  // then compares every output against the model.
  task automatic applyStimulus(input logic rstnV, input logic clrV, input logic wrV,
                               input logic rdV, input logic [WIDTH-1:0] dataV,
                               input string tag);
    int  size;
    bit  isFull, isEmpty;
    @(negedge clk);
    rst_n = rstnV;
    clr   = clrV;
    wr_en = wrV;
    rd_en = rdV;
    din   = dataV;

    size    = scoreboard.size();
    isFull  = (size == DEPTH);
    isEmpty = (size == 0);
    if (!rstnV) begin
      scoreboard.delete();
      expDout  = '0;
      expWrerr = 1'b0;
      expRderr = 1'b0;
    end else if (clrV) begin
      scoreboard.delete();
      expWrerr = 1'b0;
      expRderr = 1'b0;
    end else begin
      expWrerr = wrV && isFull;
      expRderr = rdV && isEmpty;
      if (rdV && !isEmpty) expDout = scoreboard.pop_front();
      if (wrV && !isFull)  scoreboard.push_back(dataV);
    end

    @(posedge clk);
    #1;
    size = scoreboard.size();
    checkOutput({tag, ".level"},  32'(level),       32'(size));
    checkOutput({tag, ".full"},   32'(full),        32'(size == DEPTH));
    checkOutput({tag, ".empty"},  32'(empty),       32'(size == 0));
    checkOutput({tag, ".afull"},  32'(almostfull),  32'(size >= DEPTH - AFOFF));
    checkOutput({tag, ".aempty"}, 32'(almostempty), 32'(size <= AEOFF));
    checkOutput({tag, ".wrerr"},  32'(wrerr),       32'(expWrerr));
    checkOutput({tag, ".rderr"},  32'(rderr),       32'(expRderr));
`ifdef MY_SYNC_FIFO_FWFT_EN
    if (size != 0) checkOutput({tag, ".dout"}, 32'(dout), 32'(scoreboard[0]));
    else if (!rstnV) checkOutput({tag, ".dout"}, 32'(dout), 32'h0);
`else
    checkOutput({tag, ".dout"}, 32'(dout), 32'(expDout));
`endif
  endtask

  initial begin
    rst_n    = 1'b0;
    clr      = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    din      = '0;
    expDout  = '0;
    expWrerr = 1'b0;
    expRderr = 1'b0;

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, "reset0");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, "reset1");

    for (int i = 1; i <= 16; i++)
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 9'(i), "fill");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 9'h011, "overflow");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, "idleFull");

    for (int i = 1; i <= 16; i++)
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0, "drain");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0, "underflow");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, "idleEmpty");

    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 9'(9'h0a0 + i), "preWrap");
    for (int i = 0; i < 40; i++)
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 9'(9'h100 + i), "wrapPair");

    for (int i = 0; i < 13; i++)
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 9'(9'h150 + i), "refill");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 9'h1ff, "bothFull");
    for (int i = 0; i < 15; i++)
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0, "drain2");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 9'h0cc, "bothEmpty");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0, "popOne");

    for (int i = 0; i < 9; i++)
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 9'(9'h030 + i), "toNine");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 9'h155, "clrWrite");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0, "readAfterClr");

    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 9'(9'h060 + i), "toFive");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 9'h077, "resetMid");

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 9'h0aa, "singleWrite");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, "singleHold");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0, "singleRead");

    // Random traffic with phases biased toward filling and draining.
    for (int i = 0; i < 300; i++) begin
      logic wrR, rdR, clrR;
      wrR  = (i % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rdR  = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clrR = ($urandom_range(0, 63) == 0);
      applyStimulus(1'b1, clrR, wrR, rdR, 9'($urandom_range(0, 511)), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/my_sync_fifo.md
MY_SYNC_FIFO -- requirements
Module: my_sync_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 9, data width in bits (1..72).
REQ-002 SHALL have parameter DEPTH, default 2048, entry count, power of two, 4..4096.
REQ-003 SHALL have parameter AFULL_OFFSET, default 128, almost-full threshold distance from full.
REQ-004 SHALL have parameter AEMPTY_OFFSET, default 128, almost-empty threshold distance from empty.
REQ-005 SHALL have port list:
  clk  in  1  sole clock, rising edge
  rst_n  in  1  reset, synchronous, active-low
  clr  in  1  synchronous flush
  din  in  WIDTH  write data
  wr_en  in  1  write request
  rd_en  in  1  read request
  dout  out  WIDTH  read data
  full  out  1  no free entry
  empty  out  1  no readable entry
  almostfull  out  1  level >= DEPTH-AFULL_OFFSET
  almostempty  out  1  level <= AEMPTY_OFFSET
  level  out  clog2(DEPTH)+1  current occupancy
  wrerr  out  1  rejected write, one-cycle pulse
  rderr  out  1  rejected read, one-cycle pulse

Function
REQ-006 Write SHALL be accepted when wr_en=1 and full=0 at the clock edge; din stored at write pointer, pointer +1 mod DEPTH.
REQ-007 Read SHALL be accepted when rd_en=1 and empty=0; read pointer +1 mod DEPTH.
REQ-008 wr_en=1 while full=1: write dropped, contents unchanged, wrerr=1 for exactly the next cycle.
REQ-009 rd_en=1 while empty=1: read dropped, dout unchanged, rderr=1 for exactly the next cycle.
REQ-010 Simultaneous accepted read and write: level unchanged; on full, read accepted and write rejected (wrerr); on empty, write accepted and read rejected (rderr).
REQ-011 level SHALL update the cycle after each accepted operation: +1 write only, -1 read only, 0 both.
REQ-012 full = (level==DEPTH); almostfull/almostempty SHALL be registered, derived from next-cycle level, never lag level.
REQ-013 Standard mode: empty = (level==0); dout SHALL present the popped word one cycle after an accepted read and hold otherwise.
REQ-014 Pointers SHALL wrap DEPTH-1 -> 0 without data loss or flag glitch.
REQ-015 clr=1 SHALL, next cycle, zero pointers and level, set empty/almostempty=1, clear full/almostfull/wrerr/rderr; dout held; clr overrides wr_en/rd_en same cycle.

Reset
REQ-016 rst_n=0 sampled at clk SHALL force: level=0, empty=1, almostempty=1, full=0, almostfull=0, wrerr=0, rderr=0, dout=0, pointers 0.
REQ-017 rst_n has priority over clr, wr_en, rd_en; reset mid-operation discards all contents; storage array not reset.

Configuration
REQ-018 Macro MY_SYNC_FIFO_FWFT_EN defined: first-word-fall-through; dout SHALL show head entry whenever empty=0, rd_en pops it, next word (if any) on dout the following cycle.
REQ-019 FWFT: write into empty FIFO SHALL deassert empty and drive dout one cycle after the write edge; level counts the output-stage word.
REQ-020 Macro undefined: standard mode per REQ-013 only; no FWFT logic synthesised.

Structure
REQ-021 Package my_fifo_pkg SHALL hold clog2 function, max DEPTH/WIDTH constants, and the level-width derivation shared with other FIFOs.
REQ-022 Storage SHALL be sub-module my_fifo_ram: simple dual-port, sync write, registered read, WIDTH x DEPTH, inferable as block RAM; control/flags stay in my_sync_fifo.

Verification (WIDTH=9, DEPTH=16, AFULL_OFFSET=4, AEMPTY_OFFSET=2)
REQ-023 Fill: 16 writes 0x001..0x010 -> level 16, full=1, almostfull=1 from level 12; 17th write -> wrerr pulse, level stays 16.
REQ-024 Drain: 16 reads after fill -> dout 0x001..0x010 in order, empty=1 after last; extra read -> rderr pulse, dout holds 0x010.
REQ-025 Wrap: 40 interleaved write/read pairs from level 3 -> level stays 3, data order preserved across pointer wrap.
REQ-026 Boundary: full plus rd_en&wr_en -> level 15, wrerr=1; empty plus both -> level 1, rderr=1.
REQ-027 clr at level 9 with wr_en=1 -> level 0, empty=1 next cycle, new word not stored; rst_n=0 at level 5 -> all REQ-016 values.
REQ-028 FWFT build: single write 0x0AA into empty -> empty=0, dout=0x0AA next cycle with no rd_en; rd_en -> empty=1 next cycle.
